hazard_fwd_unit: RTL and testbench

Forwarding and hazard controller for the 5-stage MIPS pipeline. Tracks the destination register of every in-flight instruction in EX, MEM and WB, and produces the registered 2-bit `addr` selects and the `enable` (force-zero) line that drive the two EX-stage operand `MUX_4` instances. Also generates the load-use stall for PC/IF-ID and inserts bubbles into EX. It sits between ID decode and the EX operand muxes.

---
 rtl/hazard_fwd_unit.sv | 148 ++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// ---------------------------------------------------------------------------
// Forwarding and hazard controller for the 5-stage MIPS pipeline.
// It tracks the destination register of the instructions in EX, MEM and WB.
// It produces the registered operand selects for the two EX operand muxes
// and the operand force-zero line. It also produces the load-use stall and
// inserts bubbles into EX.
//
// Configuration macro: HAZARD_FWD_BYPASS_EN
//   defined     : full forwarding. Only a load-use hazard stalls.
//   not defined : selects are always 00. Any RAW dependency stalls until
//                 the producer has retired from WB.
//
// Ports
//   clk         in  1       rising-edge clock
//   rst         in  1       synchronous active-high reset
//   id_valid    in  1       ID holds a real instruction
//   id_rs/rt    in  REG_AW  ID source registers
//   id_use_rs/rt in 1       instruction actually reads rs / rt
//   id_rd       in  REG_AW  ID destination register
//   id_reg_we   in  1       ID instruction writes id_rd
//   id_is_load  in  1       ID instruction is a load
//   flush       in  1       redirect from EX, squashes ID
//   fwd_a_sel   out 2       operand A select (00 RF, 01 EX/MEM, 10 MEM/WB, 11 WB latch)
//   fwd_b_sel   out 2       operand B select
//   op_zero     out 1       EX holds a bubble, operands forced to 0
//   stall       out 1       hold PC and IF/ID (combinational)
// ---------------------------------------------------------------------------
module hazard_fwd_unit #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_we,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              op_zero,
  output logic              stall
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
  } entry_t;

  localparam entry_t ENTRY_NONE = '{valid: 1'b0, rd: {REG_AW{1'b0}}, we: 1'b0, load: 1'b0};

  entry_t ex_r, mem_r, wb_r;

  logic       hit_ex_s, hit_mem_s, hit_wb_s;
  logic       hazard_s, stall_s, advance_s;
  logic [1:0] sel_a_s, sel_b_s;
  logic       unused_load_s;

  // A producer writes a real register. $0 never forwards and never stalls.
  function automatic logic is_prod(input entry_t e);
    return e.valid & e.we & (e.rd != {REG_AW{1'b0}});
  endfunction

  // A used source register matches a producer entry.
  function automatic logic src_hit(input entry_t e, input logic use_src,
                                   input logic [REG_AW-1:0] src);
    return use_src & is_prod(e) & (e.rd == src);
  endfunction

`ifdef HAZARD_FWD_BYPASS_EN
  // Youngest matching producer wins. A wb match still needs the latch,
  // because the RF write lands on the same edge as the ID read.
  function automatic logic [1:0] sel_for(input entry_t e_ex, input entry_t e_mem,
                                         input entry_t e_wb, input logic use_src,
                                         input logic [REG_AW-1:0] src);
    logic [1:0] s;
    if (src_hit(e_ex, use_src, src)) begin
      s = 2'b01;
    end else if (src_hit(e_mem, use_src, src)) begin
      s = 2'b10;
    end else if (src_hit(e_wb, use_src, src)) begin
      s = 2'b11;
    end else begin
      s = 2'b00;
    end
    return s;
  endfunction
`endif

  // Only the ex entry's load bit is consulted. The other entries keep theirs
  // so that the entries stay uniform.
  assign unused_load_s = ^{mem_r.load, wb_r.load};

  // Hazard detection, select computation and the ID->EX advance decision.
  always_comb begin
    hit_ex_s  = src_hit(ex_r,  id_use_rs, id_rs) | src_hit(ex_r,  id_use_rt, id_rt);
    hit_mem_s = src_hit(mem_r, id_use_rs, id_rs) | src_hit(mem_r, id_use_rt, id_rt);
    hit_wb_s  = src_hit(wb_r,  id_use_rs, id_rs) | src_hit(wb_r,  id_use_rt, id_rt);
`ifdef HAZARD_FWD_BYPASS_EN
    hazard_s  = hit_ex_s & ex_r.load;
    sel_a_s   = sel_for(ex_r, mem_r, wb_r, id_use_rs, id_rs);
    sel_b_s   = sel_for(ex_r, mem_r, wb_r, id_use_rt, id_rt);
`else
    // Without bypass, a consumer waits until no producer is in flight.
    hazard_s  = hit_ex_s | hit_mem_s | hit_wb_s | (hit_ex_s & ex_r.load);
    sel_a_s   = 2'b00;
    sel_b_s   = 2'b00;
`endif
    // flush overrides stall. An empty ID slot never stalls.
    stall_s   = id_valid & ~flush & hazard_s;
    advance_s = id_valid & ~flush & ~stall_s;
  end

  assign stall = stall_s;

  // Pipeline tracking entries and registered EX operand controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r      <= ENTRY_NONE;
      mem_r     <= ENTRY_NONE;
      wb_r      <= ENTRY_NONE;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
      op_zero   <= 1'b1;
    end else begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      if (advance_s) begin
        ex_r      <= '{valid: 1'b1, rd: id_rd, we: id_reg_we, load: id_is_load};
        fwd_a_sel <= sel_a_s;
        fwd_b_sel <= sel_b_s;
        op_zero   <= 1'b0;
      end else begin
        ex_r      <= ENTRY_NONE;
        fwd_a_sel <= 2'b00;
        fwd_b_sel <= 2'b00;
        op_zero   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed-vector bench for hazard_fwd_unit. Each table row drives one ID
// cycle and carries the hand-computed outputs expected during that cycle.
// stall is expected from this row's inputs. The registered sel/op_zero are
// expected from the previous row's ID instruction. The driver pushes the
// expected values. A monitor pops them at the falling edge and compares.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_use_rs, id_use_rt, id_reg_we, id_is_load, flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       op_zero, stall;

  hazard_fwd_unit #(.REG_AW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_we(id_reg_we), .id_is_load(id_is_load), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .op_zero(op_zero), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] rd;
    logic       we, ld, fl;
    logic       e_stall;
    logic [1:0] e_a, e_b;
    logic       e_opz;
  } row_t;

  typedef struct {
    int         idx;
    logic       stall;
    logic [1:0] a, b;
    logic       opz;
  } exp_t;

  row_t rows[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic row_t mk(logic r, logic v, int rs, int rt, logic urs, logic urt,
                              int rd, logic we, logic ld, logic fl,
                              logic es, logic [1:0] ea, logic [1:0] eb, logic eo);
    row_t x;
    x.rst = r; x.v = v; x.rs = rs[4:0]; x.rt = rt[4:0]; x.urs = urs; x.urt = urt;
    x.rd = rd[4:0]; x.we = we; x.ld = ld; x.fl = fl;
    x.e_stall = es; x.e_a = ea; x.e_b = eb; x.e_opz = eo;
    return x;
  endfunction

  task automatic build_rows();
    //          rst  v   rs rt urs  urt  rd we   ld   fl     stall a      b      opz
    rows.push_back(mk(1'b1,1'b0, 0, 0,1'b0,1'b0, 0,1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b1));
    rows.push_back(mk(1'b1,1'b0, 0, 0,1'b0,1'b0, 0,1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b1));
`ifdef HAZARD_FWD_BYPASS_EN
    // add $3,$1,$2 then sub $5,$3,$4
    rows.push_back(mk(1'b0,1'b1, 1, 2,1'b1,1'b1, 3,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b1));
    rows.push_back(mk(1'b0,1'b1, 3, 4,1'b1,1'b1, 5,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    rows.push_back(mk(1'b0,1'b0, 0, 0,1'b0,1'b0, 0,1'b0,1'b0,1'b0, 1'b0,2'b01,2'b00,1'b0));
    // producer $7, then consumers 1, 2 and 3 behind it
    rows.push_back(mk(1'b0,1'b1, 1, 2,1'b1,1'b1, 7,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b1));
    rows.push_back(mk(1'b0,1'b1, 7, 0,1'b1,1'b0,10,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    rows.push_back(mk(1'b0,1'b1, 0, 7,1'b1,1'b1,11,1'b1,1'b0,1'b0, 1'b0,2'b01,2'b00,1'b0));
    rows.push_back(mk(1'b0,1'b1, 7, 7,1'b1,1'b1, 0,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b10,1'b0));
    // writes to $0, then readers of $0 (including behind a load of $0)
    rows.push_back(mk(1'b0,1'b1, 0, 0,1'b1,1'b1, 0,1'b1,1'b0,1'b0, 1'b0,2'b11,2'b11,1'b0));
    rows.push_back(mk(1'b0,1'b1, 1, 0,1'b1,1'b0, 0,1'b1,1'b1,1'b0, 1'b0,2'b00,2'b00,1'b0));
    rows.push_back(mk(1'b0,1'b1, 0, 0,1'b1,1'b1,12,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    // lw $8 then add $9,$8,$8: one stall, bubble, then both sels 10
    rows.push_back(mk(1'b0,1'b1, 1, 0,1'b1,1'b0, 8,1'b1,1'b1,1'b0, 1'b0,2'b00,2'b00,1'b0));
    rows.push_back(mk(1'b0,1'b1, 8, 8,1'b1,1'b1, 9,1'b1,1'b0,1'b0, 1'b1,2'b00,2'b00,1'b0));
    rows.push_back(mk(1'b0,1'b1, 8, 8,1'b1,1'b1, 9,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b1));
    // lw $8 reading $9 (non-load producer in ex gives 01), then load-use with flush
    rows.push_back(mk(1'b0,1'b1, 9, 0,1'b1,1'b0, 8,1'b1,1'b1,1'b0, 1'b0,2'b10,2'b10,1'b0));
    rows.push_back(mk(1'b0,1'b1, 8, 8,1'b1,1'b1, 9,1'b1,1'b0,1'b1, 1'b0,2'b01,2'b00,1'b0));
    // lw $8, then load-use with rst asserted during the stall cycle
    rows.push_back(mk(1'b0,1'b1, 0, 0,1'b1,1'b0, 8,1'b1,1'b1,1'b0, 1'b0,2'b00,2'b00,1'b1));
    rows.push_back(mk(1'b1,1'b1, 8, 8,1'b1,1'b1, 9,1'b1,1'b0,1'b0, 1'b1,2'b00,2'b00,1'b0));
    rows.push_back(mk(1'b0,1'b1, 8, 8,1'b1,1'b1, 9,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b1));
    rows.push_back(mk(1'b0,1'b0, 0, 0,1'b0,1'b0, 0,1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    rows.push_back(mk(1'b0,1'b0, 0, 0,1'b0,1'b0, 0,1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b1));
`else
    // add $3 then sub $5,$3,$3: three stall cycles, then sub enters with 00
    rows.push_back(mk(1'b0,1'b1, 1, 2,1'b1,1'b1, 3,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b1));
    rows.push_back(mk(1'b0,1'b1, 3, 3,1'b1,1'b1, 5,1'b1,1'b0,1'b0, 1'b1,2'b00,2'b00,1'b0));
    rows.push_back(mk(1'b0,1'b1, 3, 3,1'b1,1'b1, 5,1'b1,1'b0,1'b0, 1'b1,2'b00,2'b00,1'b1));
    rows.push_back(mk(1'b0,1'b1, 3, 3,1'b1,1'b1, 5,1'b1,1'b0,1'b0, 1'b1,2'b00,2'b00,1'b1));
    rows.push_back(mk(1'b0,1'b1, 3, 3,1'b1,1'b1, 5,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b1));
    rows.push_back(mk(1'b0,1'b0, 0, 0,1'b0,1'b0, 0,1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    // write to $0 then reader of $0: no stall
    rows.push_back(mk(1'b0,1'b1, 1, 0,1'b1,1'b0, 0,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b1));
    rows.push_back(mk(1'b0,1'b1, 0, 0,1'b1,1'b1,12,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    // consumer of $12 with flush (no stall), then stalled with rst asserted
    rows.push_back(mk(1'b0,1'b1,12, 0,1'b1,1'b0,13,1'b1,1'b0,1'b1, 1'b0,2'b00,2'b00,1'b0));
    rows.push_back(mk(1'b1,1'b1,12, 0,1'b1,1'b0,13,1'b1,1'b0,1'b0, 1'b1,2'b00,2'b00,1'b1));
    rows.push_back(mk(1'b0,1'b1,12, 0,1'b1,1'b0,13,1'b1,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b1));
    rows.push_back(mk(1'b0,1'b0, 0, 0,1'b0,1'b0, 0,1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b0));
    rows.push_back(mk(1'b0,1'b0, 0, 0,1'b0,1'b0, 0,1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,1'b1));
`endif
  endtask

  task automatic check(string name, int idx, logic [1:0] act, logic [1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s row %0d: got %b, expected %b", name, idx, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectations.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall",     e.idx, {1'b0, stall},   {1'b0, e.stall});
      check("fwd_a_sel", e.idx, fwd_a_sel,       e.a);
      check("fwd_b_sel", e.idx, fwd_b_sel,       e.b);
      check("op_zero",   e.idx, {1'b0, op_zero}, {1'b0, e.opz});
    end
  end

  // Driver: apply one row per cycle shortly after the rising edge.
  initial begin
    exp_t e;
    rst = 1'b1; id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_reg_we = 1'b0; id_is_load = 1'b0;
    flush = 1'b0;
    build_rows();
    @(posedge clk);
    foreach (rows[i]) begin
      #1;
      rst = rows[i].rst; id_valid = rows[i].v; id_rs = rows[i].rs; id_rt = rows[i].rt;
      id_use_rs = rows[i].urs; id_use_rt = rows[i].urt; id_rd = rows[i].rd;
      id_reg_we = rows[i].we; id_is_load = rows[i].ld; flush = rows[i].fl;
      e.idx = i; e.stall = rows[i].e_stall; e.a = rows[i].e_a; e.b = rows[i].e_b;
      e.opz = rows[i].e_opz;
      exp_q.push_back(e);
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
